// File: rtl/frv_pipe_skid.sv
// rtl/frv_pipe_skid.sv - two-entry registered valid/ready skid buffer between dispatch and execute
module frv_pipe_skid #(
  parameter int RLEN = 112
) (
  input  logic            g_clk,
  input  logic            g_reset,
  input  logic            flush,
  input  logic            i_valid,
  output logic            i_ready,
  input  logic [RLEN-1:0] i_data,
  output logic            o_valid,
  input  logic            o_ready,
  output logic [RLEN-1:0] o_data,
  output logic [1:0]      o_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } count_t;

  count_t            count_q, count_d;
  logic [RLEN-1:0]   main_q, main_d;
  logic [RLEN-1:0]   skid_q, skid_d;
  logic              in_xfer;
  logic              out_xfer;

  // Ready/valid decode from state only, so o_ready never reaches i_ready.
  assign i_ready  = (count_q != FULL) && !g_reset;
  assign o_valid  = (count_q != EMPTY);
  assign o_data   = main_q;
  assign o_count  = count_q;
  assign in_xfer  = i_valid && i_ready;
  assign out_xfer = o_valid && o_ready;

  always_comb begin
    count_d = count_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      count_d = EMPTY;
    end else begin
      case (count_q)
        EMPTY: begin
          if (in_xfer) begin
            count_d = ONE;
            main_d  = i_data;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_d = i_data;
          end else if (in_xfer) begin
            count_d = FULL;
            skid_d  = i_data;
          end else if (out_xfer) begin
            count_d = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            count_d = ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          count_d = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      count_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      count_q <= count_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_frv_pipe_skid.sv
// tb/tb_frv_pipe_skid.sv - directed bench for frv_pipe_skid at RLEN=32
module tb_frv_pipe_skid;

  localparam int RLEN = 32;

  logic            g_clk;
  logic            g_reset;
  logic            flush;
  logic            i_valid;
  logic            i_ready;
  logic [RLEN-1:0] i_data;
  logic            o_valid;
  logic            o_ready;
  logic [RLEN-1:0] o_data;
  logic [1:0]      o_count;

  int n_checks;
  int n_pass;

  frv_pipe_skid #(.RLEN(RLEN)) dut (
    .g_clk   (g_clk),
    .g_reset (g_reset),
    .flush   (flush),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_count (o_count)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge g_clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    g_reset  = 1'b1;
    flush    = 1'b0;
    i_valid  = 1'b1;
    i_data   = 32'hDEAD_BEEF;
    o_ready  = 1'b0;

    // Reset / idle
    step();
    step();
    chk("rst_i_ready", {31'd0, i_ready}, 32'd0);
    chk("rst_o_valid", {31'd0, o_valid}, 32'd0);
    g_reset = 1'b0;
    i_valid = 1'b0;
    #1;
    chk("idle_count", {30'd0, o_count}, 32'd0);
    chk("idle_i_ready", {31'd0, i_ready}, 32'd1);
    chk("idle_o_data", o_data, 32'd0);

    // Streaming
    o_ready = 1'b1;
    i_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      i_data = k;
      step();
      chk("stream_data", o_data, k);
      chk("stream_valid", {31'd0, o_valid}, 32'd1);
      chk("stream_count", {30'd0, o_count}, 32'd1);
      chk("stream_i_ready", {31'd0, i_ready}, 32'd1);
    end
    i_valid = 1'b0;
    step();
    chk("stream_drain", {31'd0, o_valid}, 32'd0);

    // Skid fill and drain
    o_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = 32'hA;
    step();
    chk("skid_one_i_ready", {31'd0, i_ready}, 32'd1);
    i_data = 32'hB;
    step();
    chk("skid_full_count", {30'd0, o_count}, 32'd2);
    chk("skid_full_i_ready", {31'd0, i_ready}, 32'd0);
    chk("skid_full_data", o_data, 32'hA);
    i_data = 32'hC;
    step();
    chk("skid_hold_data", o_data, 32'hA);
    chk("skid_hold_count", {30'd0, o_count}, 32'd2);
    o_ready = 1'b1;
    step();
    chk("skid_drain_b", o_data, 32'hB);
    chk("skid_drain_b_cnt", {30'd0, o_count}, 32'd1);
    chk("skid_recover_rdy", {31'd0, i_ready}, 32'd1);
    step();
    chk("skid_drain_c", o_data, 32'hC);
    chk("skid_drain_c_cnt", {30'd0, o_count}, 32'd1);
    i_valid = 1'b0;
    step();
    chk("skid_empty", {31'd0, o_valid}, 32'd0);

    // Flush in FULL
    o_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = 32'hA;
    step();
    i_data = 32'hB;
    step();
    chk("fl_full_count", {30'd0, o_count}, 32'd2);
    i_valid = 1'b0;
    flush   = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_o_valid", {31'd0, o_valid}, 32'd0);
    chk("fl_count", {30'd0, o_count}, 32'd0);
    chk("fl_i_ready", {31'd0, i_ready}, 32'd1);
    i_valid = 1'b1;
    i_data  = 32'hE;
    o_ready = 1'b1;
    step();
    chk("fl_first_out", o_data, 32'hE);
    chk("fl_first_valid", {31'd0, o_valid}, 32'd1);
    i_valid = 1'b0;
    step();

    // Flush with simultaneous input
    o_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = 32'h5;
    step();
    chk("fi_one_data", o_data, 32'h5);
    flush  = 1'b1;
    i_data = 32'h6;
    step();
    flush   = 1'b0;
    i_valid = 1'b0;
    chk("fi_o_valid", {31'd0, o_valid}, 32'd0);
    chk("fi_count", {30'd0, o_count}, 32'd0);
    step();
    chk("fi_still_empty", {31'd0, o_valid}, 32'd0);

    // Reset mid-stall
    i_valid = 1'b1;
    i_data  = 32'hA;
    step();
    i_data = 32'hB;
    step();
    chk("rs_full_count", {30'd0, o_count}, 32'd2);
    i_valid = 1'b0;
    g_reset = 1'b1;
    step();
    chk("rs_i_ready_low", {31'd0, i_ready}, 32'd0);
    g_reset = 1'b0;
    #1;
    chk("rs_count", {30'd0, o_count}, 32'd0);
    chk("rs_o_data", o_data, 32'd0);
    chk("rs_o_valid", {31'd0, o_valid}, 32'd0);
    o_ready = 1'b1;
    step();
    chk("rs_no_stale", {31'd0, o_valid}, 32'd0);
    chk("rs_i_ready", {31'd0, i_ready}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
